// File: rtl/alu_rr_scheduler_if.sv
// alu_rr_scheduler_if: bundles the requester, ALU and response signals of alu_rr_scheduler.
//   slave  : scheduler view (takes requests and ALU results, drives grants, ALU operands and
//            responses).
//   master : environment view (requesters, the ALU_8bit datapath and the response consumer).
// Signals:
//   req_valid/req_ready [NREQ]  per-requester handshake, req_ready is a one-hot grant
//   req_op [2*NREQ], req_a/req_b [WIDTH*NREQ], req_cin [NREQ]  per-requester operation slices
//   alu_a/alu_b/alu_op/alu_cin  registered ALU operands; alu_result/alu_cout  ALU outputs
//   rsp_valid/rsp_ready, rsp_id, rsp_result, rsp_cout, rsp_err  tagged response channel
interface alu_rr_scheduler_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREQ  = 4
);
  localparam int unsigned IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [2*NREQ-1:0]     req_op;
  logic [WIDTH*NREQ-1:0] req_a;
  logic [WIDTH*NREQ-1:0] req_b;
  logic [NREQ-1:0]       req_cin;

  logic [WIDTH-1:0]      alu_a;
  logic [WIDTH-1:0]      alu_b;
  logic                  alu_cin;
  logic [1:0]            alu_op;
  logic [WIDTH-1:0]      alu_result;
  logic                  alu_cout;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_result;
  logic                  rsp_cout;
  logic                  rsp_err;

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_cin, alu_result, alu_cout, rsp_ready,
    output req_ready, alu_a, alu_b, alu_cin, alu_op, rsp_valid, rsp_id, rsp_result, rsp_cout,
           rsp_err
  );

  modport master (
    output req_valid, req_op, req_a, req_b, req_cin, alu_result, alu_cout, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_cin, alu_op, rsp_valid, rsp_id, rsp_result, rsp_cout,
           rsp_err
  );
endinterface

// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: shares one ALU_8bit (AND/OR/ADD with carry) among NREQ requesters.
// A round-robin arbiter picks one requester in IDLE, its operation is registered onto the ALU
// inputs (EXEC), the ALU result is captured and returned with the requester id (RESP). Exactly
// one operation is in flight; best case is one operation every three cycles.
// Ports:
//   clk  clock, rising edge
//   rst  synchronous active-high reset, highest priority
//   bus  alu_rr_scheduler_if.slave: requester handshake/slices, ALU operands/results,
//        response channel (see the interface file)
// Optional build macro ALU_RR_SCHED_OPCHK_EN: reserved op 11 is not sent to the ALU (inputs
// forced to zero) and the response reports rsp_err=1 with a zero result. Without it, op 11 is
// forwarded unchanged and rsp_err is tied low.
// WIDTH/NREQ must match the parameters of the connected interface instance.
module alu_rr_scheduler #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREQ  = 4
) (
  input logic               clk,
  input logic               rst,
  alu_rr_scheduler_if.slave bus
);
  localparam int unsigned IDW = $clog2(NREQ);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [1:0]       alu_op_q, alu_op_d;
  logic             alu_cin_q, alu_cin_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_cout_q, rsp_cout_d;
`ifdef ALU_RR_SCHED_OPCHK_EN
  logic             err_pend_q, err_pend_d;
  logic             rsp_err_q, rsp_err_d;
`endif

  // Round-robin search starting at ptr_q and wrapping past NREQ-1.
  logic             gnt_found;
  logic [IDW-1:0]   gnt_idx;
  int unsigned      cand;
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = (32'(ptr_q) + k) % NREQ;
      if (!gnt_found && bus.req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'(cand);
      end
    end
  end

  // Operand slice of the winning requester.
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic             sel_cin;
  always_comb begin
    sel_op  = '0;
    sel_a   = '0;
    sel_b   = '0;
    sel_cin = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (IDW'(k) == gnt_idx) begin
        sel_op  = bus.req_op[2*k +: 2];
        sel_a   = bus.req_a[k*WIDTH +: WIDTH];
        sel_b   = bus.req_b[k*WIDTH +: WIDTH];
        sel_cin = bus.req_cin[k];
      end
    end
  end

  logic [NREQ-1:0] req_ready;
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    id_d         = id_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    alu_cin_d    = alu_cin_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_cout_d   = rsp_cout_q;
`ifdef ALU_RR_SCHED_OPCHK_EN
    err_pend_d   = err_pend_q;
    rsp_err_d    = rsp_err_q;
`endif
    req_ready    = '0;

    unique case (state_q)
      StIdle: begin
        if (gnt_found) begin
          req_ready = NREQ'(1) << gnt_idx;
          id_d      = gnt_idx;
          alu_a_d   = sel_a;
          alu_b_d   = sel_b;
          alu_op_d  = sel_op;
          alu_cin_d = sel_cin;
`ifdef ALU_RR_SCHED_OPCHK_EN
          err_pend_d = (sel_op == 2'b11);
          // Keep the ALU inputs quiet for a reserved op; it still consumes a slot.
          if (sel_op == 2'b11) begin
            alu_a_d   = '0;
            alu_b_d   = '0;
            alu_op_d  = 2'b00;
            alu_cin_d = 1'b0;
          end
`endif
          state_d = StExec;
        end
      end
      StExec: begin
        rsp_valid_d  = 1'b1;
        rsp_result_d = bus.alu_result;
        rsp_cout_d   = bus.alu_cout;
`ifdef ALU_RR_SCHED_OPCHK_EN
        rsp_err_d = err_pend_q;
        if (err_pend_q) begin
          rsp_result_d = '0;
          rsp_cout_d   = 1'b0;
        end
`endif
        state_d = StResp;
      end
      StResp: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          ptr_d       = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // No grant may be observed while reset is asserted.
    if (rst) req_ready = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      id_q         <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      alu_cin_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_cout_q   <= 1'b0;
`ifdef ALU_RR_SCHED_OPCHK_EN
      err_pend_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      id_q         <= id_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      alu_cin_q    <= alu_cin_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_cout_q   <= rsp_cout_d;
`ifdef ALU_RR_SCHED_OPCHK_EN
      err_pend_q   <= err_pend_d;
      rsp_err_q    <= rsp_err_d;
`endif
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.alu_cin    = alu_cin_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_cout   = rsp_cout_q;
`ifdef ALU_RR_SCHED_OPCHK_EN
  assign bus.rsp_err    = rsp_err_q;
`else
  assign bus.rsp_err    = 1'b0;
`endif
endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Testbench for alu_rr_scheduler: directed requests with hand-computed responses pushed into
// an expectation queue; a monitor pops and compares on every accepted response. A small
// behavioural ALU (op 11 modelled as XOR) closes the loop on the alu_* outputs.
module tb_alu_rr_scheduler;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned NREQ  = 4;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] res;
    logic       cout;
    logic       err;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  rsp_t exp_q[$];
  logic [8:0] alu_sum;

  alu_rr_scheduler_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  alu_rr_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural ALU_8bit.
  always_comb begin
    alu_sum = '0;
    case (bus.alu_op)
      2'b00:   alu_sum = {1'b0, bus.alu_a & bus.alu_b};
      2'b01:   alu_sum = {1'b0, bus.alu_a | bus.alu_b};
      2'b10:   alu_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {8'd0, bus.alu_cin};
      default: alu_sum = {1'b0, bus.alu_a ^ bus.alu_b};
    endcase
    bus.alu_result = alu_sum[7:0];
    bus.alu_cout   = alu_sum[8];
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endfunction

  // Scoreboard monitor: compare every accepted response against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 32'(exp_q.size()), 32'd1);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
        chk("rsp_result", 32'(bus.rsp_result), 32'(e.res));
        chk("rsp_cout", 32'(bus.rsp_cout), 32'(e.cout));
        chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic cin);
    bus.req_op[2*i +: 2] = op;
    bus.req_a[i*8 +: 8]  = a;
    bus.req_b[i*8 +: 8]  = b;
    bus.req_cin[i]       = cin;
    bus.req_valid[i]     = 1'b1;
  endtask

  task automatic push(input logic [1:0] id, input logic [7:0] res, input logic cout,
                      input logic err);
    rsp_t e;
    e.id = id; e.res = res; e.cout = cout; e.err = err;
    exp_q.push_back(e);
  endtask

  // Wait (bounded) for any grant, require it to be requester i, then drop its request.
  task automatic wait_grant(input int i);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.req_ready != '0) break;
    end
    chk($sformatf("grant_%0d", i), 32'(bus.req_ready), 32'(1) << i);
    @(posedge clk);
    #1;
    bus.req_valid[i] = 1'b0;
  endtask

  // Wait (bounded) until every expected response has been consumed.
  task automatic wait_idle();
    for (int k = 0; k < 60 && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_cin   = '0;
    bus.rsp_ready = 1'b1;
    tick();
    tick();

    // Reset state, with a request already pending to prove req_ready is gated.
    set_req(0, 2'b10, 8'h0F, 8'h01, 1'b0);
    @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_alu", {bus.alu_a, bus.alu_b, 6'd0, bus.alu_op, 7'd0, bus.alu_cin}, 32'd0);
    chk("rst_rsp", {21'd0, bus.rsp_id, bus.rsp_result, bus.rsp_cout}, 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);

    // Single request: one-cycle grant pulse, response two cycles later.
    push(2'd0, 8'h10, 1'b0, 1'b0);
    @(posedge clk); #1; rst = 1'b0;
    wait_grant(0);
    @(negedge clk);
    chk("ready_pulse", 32'(bus.req_ready), 32'd0);
    chk("exec_alu_a", 32'(bus.alu_a), 32'h0F);
    chk("exec_alu_op", 32'(bus.alu_op), 32'd2);
    chk("exec_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    chk("resp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    wait_idle();

    // Carry in and carry out.
    set_req(2, 2'b10, 8'hFF, 8'h01, 1'b1);
    push(2'd2, 8'h01, 1'b1, 1'b0);
    wait_grant(2);
    wait_idle();

    // Round-robin: all four pending from reset.
    rst = 1'b1;
    set_req(0, 2'b00, 8'hAA, 8'hCC, 1'b0);
    set_req(1, 2'b01, 8'hAA, 8'hCC, 1'b0);
    set_req(2, 2'b10, 8'h0F, 8'h01, 1'b0);
    set_req(3, 2'b10, 8'hFF, 8'h01, 1'b0);
    push(2'd0, 8'h88, 1'b0, 1'b0);
    push(2'd1, 8'hEE, 1'b0, 1'b0);
    push(2'd2, 8'h10, 1'b0, 1'b0);
    push(2'd3, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    chk("rst_gate_all", 32'(bus.req_ready), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    for (int k = 0; k < 4; k++) wait_grant(k);
    wait_idle();

    // Backpressure: pointer wrapped to 0, req3 granted, req0 must wait for acceptance.
    bus.rsp_ready = 1'b0;
    set_req(3, 2'b01, 8'h0F, 8'hF0, 1'b0);
    push(2'd3, 8'hFF, 1'b0, 1'b0);
    wait_grant(3);
    set_req(0, 2'b00, 8'hF0, 8'h3C, 1'b0);
    push(2'd0, 8'h30, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_result", {22'd0, bus.rsp_id, bus.rsp_result}, {22'd0, 2'd3, 8'hFF});
      chk("bp_no_grant", 32'(bus.req_ready), 32'd0);
    end
    @(posedge clk); #1; bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_accept_cycle", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    chk("bp_next_grant", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1; bus.req_valid[0] = 1'b0;
    wait_idle();

    // Reset while req2 executes: dropped, pointer back to 0, req1 then req3 served.
    set_req(2, 2'b10, 8'h11, 8'h22, 1'b0);
    wait_grant(2);
    set_req(1, 2'b10, 8'h80, 8'h80, 1'b0);
    set_req(3, 2'b00, 8'hFF, 8'h0F, 1'b0);
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mid_rst_alu", {bus.alu_a, bus.alu_b, 14'd0, bus.alu_op}, 32'd0);
    chk("mid_rst_rsp", {21'd0, bus.rsp_id, bus.rsp_result, bus.rsp_cout}, 32'd0);
    chk("mid_rst_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    push(2'd1, 8'h00, 1'b1, 1'b0);
    push(2'd3, 8'h0F, 1'b0, 1'b0);
    wait_grant(1);
    wait_grant(3);
    wait_idle();

    // Reserved op 11.
    set_req(1, 2'b11, 8'h55, 8'h0F, 1'b0);
`ifdef ALU_RR_SCHED_OPCHK_EN
    push(2'd1, 8'h00, 1'b0, 1'b1);
`else
    push(2'd1, 8'h5A, 1'b0, 1'b0);
`endif
    wait_grant(1);
    @(negedge clk);
`ifdef ALU_RR_SCHED_OPCHK_EN
    chk("rsv_alu_op", 32'(bus.alu_op), 32'd0);
    chk("rsv_alu_a", 32'(bus.alu_a), 32'h00);
`else
    chk("rsv_alu_op", 32'(bus.alu_op), 32'd3);
    chk("rsv_alu_a", 32'(bus.alu_a), 32'h55);
`endif
    wait_idle();

    repeat (3) tick();
    chk("final_queue", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_rr_scheduler.md
Name: alu_rr_scheduler

Overview:
- Shares one ALU_8bit instance (AND/OR/ADD with carry) among NREQ requesters.
- Arbitrates round-robin, registers the winning operands onto the ALU inputs, captures result/carry and returns a tagged response over a valid/ready handshake.
- Sits between requester blocks and the single ALU datapath. Exactly one operation in flight at a time.

Parameters:
- WIDTH, 8, operand/result width; must match the ALU_8bit WIDTH.
- NREQ, 4, number of requesters; legal range 2..8.
- IDW, $clog2(NREQ), width of the requester ID (localparam).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- req_valid  input  NREQ  bit i: requester i has an operation pending.
- req_ready  output  NREQ  one-hot grant; bit i high when the requester i transfer completes this cycle.
- req_op  input  2*NREQ  requester i op at [2*i +: 2]; 00 AND, 01 OR, 10 ADD, 11 reserved.
- req_a  input  WIDTH*NREQ  requester i operand A at [i*WIDTH +: WIDTH].
- req_b  input  WIDTH*NREQ  requester i operand B, same slicing.
- req_cin  input  NREQ  requester i carry-in.
- alu_a, alu_b  output  WIDTH  registered operands to the ALU.
- alu_cin  output  1  registered carry-in to the ALU.
- alu_op  output  2  registered op to the ALU.
- alu_result  input  WIDTH  ALU result, combinational from alu_*.
- alu_cout  input  1  ALU carry-out.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer accepts response.
- rsp_id  output  IDW  index of the requester the response belongs to.
- rsp_result  output  WIDTH  captured result.
- rsp_cout  output  1  captured carry-out.
- rsp_err  output  1  reserved op flag (see Optional Feature).

Behaviour:
- Reset (synchronous, takes priority over everything):
  - State goes to IDLE and the RR pointer to 0.
  - alu_a, alu_b, alu_op, alu_cin, rsp_valid, rsp_id, rsp_result, rsp_cout and rsp_err all go to 0.
  - req_ready is 0 during reset cycles.
- States: IDLE, EXEC, RESP.
- IDLE:
  - req_ready is combinational: the one-hot bit of the first requester with req_valid=1, searching from ptr upward with wrap (ptr, ptr+1, ..., NREQ-1, 0, ..., ptr-1).
  - If any req_valid is set, the granted slice is latched into the alu_* regs and the grant index into the id reg; go to EXEC.
  - Otherwise req_ready is 0 and the state stays IDLE.
- EXEC:
  - req_ready is 0.
  - Sample alu_result/alu_cout into rsp_result/rsp_cout, set rsp_valid=1, go to RESP.
- RESP:
  - req_ready is 0. rsp_* stay stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_ready=1: clear rsp_valid, set ptr = (grant+1) mod NREQ, go to IDLE.
  - rsp_ready while rsp_valid=0 is ignored.
- Latency and throughput:
  - Grant at edge t; rsp_valid high after edge t+2.
  - Best-case throughput is one op per 3 cycles (rsp_ready tied high).
- alu_* hold their last values outside EXEC. No combinational path from req_* to alu_*.
- Fairness: a continuously asserting requester waits at most NREQ-1 other transactions.
- Requester rules:
  - req_valid may deassert without a grant; no grant is then given.
  - Operands must be stable while req_valid=1.
- Wrap: ptr = NREQ-1 followed by a grant wraps the pointer to 0. A search from ptr wraps past NREQ-1.
- Reset mid-EXEC or mid-RESP: the in-flight operation is dropped, no response is produced, and ptr returns to 0.

Optional Feature:
- Macro: ALU_RR_SCHED_OPCHK_EN.
- Defined:
  - An op 11 grant still takes a slot and follows the same IDLE→EXEC→RESP timing.
  - alu_op is loaded with 00 and alu_a/alu_b with 0 (ALU inputs stay quiet).
  - Response carries rsp_result=0, rsp_cout=0, rsp_err=1.
  - Legal ops give rsp_err=0.
- Undefined:
  - op 11 is forwarded unchanged to the ALU and its outputs are captured as-is.
  - rsp_err is tied 0.

Test Plan:
- Single req: req0 op=10, A=8'h0F, B=8'h01, cin=0, rsp_ready=1 → req_ready[0] pulses for 1 cycle; rsp_valid 2 cycles later with id=0, result=8'h10, cout=0.
- Carry: req2 op=10, A=8'hFF, B=8'h01, cin=1 → result=8'h01, cout=1, id=2.
- Round-robin: all 4 requesters valid from reset, each requester drops valid after its own grant. req0 AND AA/CC, req1 OR AA/CC, req2 ADD 0F/01, req3 ADD FF/01 → responses in id order 0,1,2,3 with results 88, EE, 10, 00 (cout=1).
- Backpressure: rsp_ready=0 for 5 cycles in RESP → rsp_* stable, req_ready stays 0, no new grant; grant follows on the cycle after rsp_ready=1.
- Reset mid-op: assert rst in EXEC → next cycle rsp_valid=0, all outputs 0; a pending req1 is granted first after reset (ptr=0, req0 idle).
- Reserved op with ALU_RR_SCHED_OPCHK_EN: req1 op=11, A=8'h55 → alu_op=00, rsp_result=0, rsp_err=1, id=1; without the macro → rsp_err=0 and alu_op=11.
